// File: rtl/colour_pkg.sv
// colour_pkg: shared types and sample decode for the colour lock path
//   colour_t        - decoded colour (NONE/RED/GREEN/BLUE)
//   lock_state_t    - lock FSM states
//   decode_t        - decoded colour plus ambiguous flag
//   flags_to_colour - turns the three detector flags into a decode_t
package colour_pkg;

    typedef enum logic [1:0] {COL_NONE, COL_RED, COL_GREEN, COL_BLUE} colour_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_LOCKED, ST_HOLD} lock_state_t;

    typedef struct packed {
        colour_t colour;
        logic    ambiguous;
    } decode_t;

    localparam int STAT_W = 16;

    // colour is the highest-priority raised flag; when ambiguous is set the
    // caller must treat the sample as COL_NONE
    function automatic decode_t flags_to_colour(input logic red, input logic green, input logic blue);
        decode_t d;
        d.ambiguous = (red & green) | (red & blue) | (green & blue);
        d.colour    = red ? COL_RED : green ? COL_GREEN : blue ? COL_BLUE : COL_NONE;
        return d;
    endfunction

endpackage

// File: rtl/sample_watchdog.sv
// sample_watchdog: flags a stalled sample stream after STALE_CYCLES quiet cycles
//   clk, rst_n    - clock, asynchronous active-low reset
//   kick          - sample strobe; restarts the quiet-cycle count
//   clear         - synchronous soft clear of count and stale
//   stale         - registered, high once STALE_CYCLES cycles passed without kick
//   timeout_pulse - combinational, high in the cycle whose edge declares stale
module sample_watchdog #(
    parameter int STALE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic clear,
    output logic stale,
    output logic timeout_pulse
);

    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STALE_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(STALE_CYCLES);

    logic [CW-1:0] cnt;

    // fires on the edge that would bring the count to STALE_CYCLES; once the
    // count saturates it cannot fire again until the next kick
    assign timeout_pulse = !clear && !kick && cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            stale <= 1'b0;
        end else if (clear || kick) begin
            cnt   <= '0;
            stale <= 1'b0;
        end else begin
            if (cnt != SAT) cnt <= cnt + 1'b1;
            if (timeout_pulse) stale <= 1'b1;
        end
    end

endmodule

// File: rtl/colour_lock_fsm.sv
// colour_lock_fsm: debounced, hysteretic colour lock from per-frame detector flags
//   clk, rst_n        - clock, asynchronous active-low reset
//   sample_valid      - one-cycle strobe, detector flags valid this cycle
//   red/green/blue_detected - detector flags
//   clear             - synchronous soft clear (FSM and watchdog, not stats)
//   locked_colour     - 0 none, 1 red, 2 green, 3 blue (LOCKED/HOLD only)
//   lock_valid        - high in LOCKED or HOLD
//   lock_event        - one-cycle pulse on entering LOCKED from IDLE/CAND
//   release_event     - one-cycle pulse on lock loss (misses or stale)
//   candidate_count   - consecutive matching samples, holds LOCK_FRAMES while locked
//   stale             - no sample for at least STALE_CYCLES cycles
//   lock_count, conflict_count - saturating stats, only with COLOUR_LOCK_STATS_EN,
//                       otherwise tied to 0
module colour_lock_fsm
    import colour_pkg::*;
#(
    parameter int LOCK_FRAMES    = 4,
    parameter int RELEASE_FRAMES = 3,
    parameter int STALE_CYCLES   = 2_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_valid,
    input  logic                             red_detected,
    input  logic                             green_detected,
    input  logic                             blue_detected,
    input  logic                             clear,
    output logic [1:0]                       locked_colour,
    output logic                             lock_valid,
    output logic                             lock_event,
    output logic                             release_event,
    output logic [$clog2(LOCK_FRAMES+1)-1:0] candidate_count,
    output logic                             stale,
    output logic [STAT_W-1:0]                lock_count,
    output logic [STAT_W-1:0]                conflict_count
);

    localparam int CW = $clog2(LOCK_FRAMES + 1);
    localparam int MW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);
    localparam logic [MW-1:0] REL_N  = MW'(RELEASE_FRAMES);

    lock_state_t   state, nxt_state;
    colour_t       colour, nxt_colour, sample_colour;
    logic [CW-1:0] nxt_cand;
    logic [MW-1:0] miss, nxt_miss;
    logic          nxt_lock_ev, nxt_rel_ev, to_idle, nxt_held;
    logic          timeout;
    decode_t       dec;

    assign dec           = flags_to_colour(red_detected, green_detected, blue_detected);
    assign sample_colour = dec.ambiguous ? COL_NONE : dec.colour;

    sample_watchdog #(
        .STALE_CYCLES(STALE_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .kick         (sample_valid),
        .clear        (clear),
        .stale        (stale),
        .timeout_pulse(timeout)
    );

    always_comb begin
        nxt_state   = state;
        nxt_colour  = colour;
        nxt_cand    = candidate_count;
        nxt_miss    = miss;
        nxt_lock_ev = 1'b0;
        nxt_rel_ev  = 1'b0;
        to_idle     = 1'b0;
        if (clear) begin
            to_idle = 1'b1;
        end else if (sample_valid) begin
            case (state)
                ST_IDLE, ST_CAND: begin
                    if (state == ST_CAND && sample_colour == colour) begin
                        nxt_cand = candidate_count + 1'b1;
                        if (nxt_cand == LOCK_N) begin
                            nxt_state   = ST_LOCKED;
                            nxt_lock_ev = 1'b1;
                        end
                    end else if (sample_colour != COL_NONE) begin
                        // a new colour always seeds a fresh candidate
                        nxt_colour  = sample_colour;
                        nxt_cand    = CW'(1);
                        nxt_state   = LOCK_FRAMES == 1 ? ST_LOCKED : ST_CAND;
                        nxt_lock_ev = LOCK_FRAMES == 1;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
                default: begin
                    // LOCKED has miss==0, so both states share the miss ladder
                    if (sample_colour == colour) begin
                        nxt_state = ST_LOCKED;
                        nxt_miss  = '0;
                    end else begin
                        nxt_miss  = miss + 1'b1;
                        nxt_state = ST_HOLD;
                        if (nxt_miss == REL_N) begin
                            to_idle    = 1'b1;
                            nxt_rel_ev = 1'b1;
                        end
                    end
                end
            endcase
        end else if (timeout) begin
            to_idle    = 1'b1;
            nxt_rel_ev = state == ST_LOCKED || state == ST_HOLD;
        end
        if (to_idle) begin
            nxt_state  = ST_IDLE;
            nxt_colour = COL_NONE;
            nxt_cand   = '0;
            nxt_miss   = '0;
        end
        nxt_held = nxt_state == ST_LOCKED || nxt_state == ST_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            colour          <= COL_NONE;
            candidate_count <= '0;
            miss            <= '0;
            lock_event      <= 1'b0;
            release_event   <= 1'b0;
            locked_colour   <= 2'd0;
            lock_valid      <= 1'b0;
        end else begin
            state           <= nxt_state;
            colour          <= nxt_colour;
            candidate_count <= nxt_cand;
            miss            <= nxt_miss;
            lock_event      <= nxt_lock_ev;
            release_event   <= nxt_rel_ev;
            locked_colour   <= nxt_held ? nxt_colour : COL_NONE;
            lock_valid      <= nxt_held;
        end
    end

`ifdef COLOUR_LOCK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_count     <= '0;
            conflict_count <= '0;
        end else begin
            if (nxt_lock_ev && lock_count != '1) lock_count <= lock_count + 1'b1;
            // samples dropped by a coincident clear are not counted
            if (sample_valid && !clear && dec.ambiguous && conflict_count != '1)
                conflict_count <= conflict_count + 1'b1;
        end
    end
`else
    assign lock_count     = '0;
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_colour_lock_fsm.sv
// tb_colour_lock_fsm: self-checking bench for colour_lock_fsm (table vectors + scoreboard)
module tb_colour_lock_fsm;

    typedef struct packed {
        logic [1:0] col;
        logic       lv;
        logic       le;
        logic       re;
        logic [2:0] cc;
        logic       st;
    } out_t;

    typedef struct {
        logic       sv;
        logic [2:0] rgb;
        logic       clr;
        out_t       exp;
    } vec_t;

    localparam logic [2:0] N = 3'b000, R = 3'b100, G = 3'b010, B = 3'b001;
    localparam logic [2:0] RG = 3'b110, RGB = 3'b111;
    localparam int STALE = 40;

    logic        clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0, clear = 1'b0;
    logic        red_detected = 1'b0, green_detected = 1'b0, blue_detected = 1'b0;
    logic [1:0]  locked_colour;
    logic        lock_valid, lock_event, release_event, stale;
    logic [2:0]  candidate_count;
    logic [15:0] lock_count, conflict_count;

    int   errors = 0, checks = 0;
    out_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    colour_lock_fsm #(
        .LOCK_FRAMES   (4),
        .RELEASE_FRAMES(3),
        .STALE_CYCLES  (STALE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .red_detected   (red_detected),
        .green_detected (green_detected),
        .blue_detected  (blue_detected),
        .clear          (clear),
        .locked_colour  (locked_colour),
        .lock_valid     (lock_valid),
        .lock_event     (lock_event),
        .release_event  (release_event),
        .candidate_count(candidate_count),
        .stale          (stale),
        .lock_count     (lock_count),
        .conflict_count (conflict_count)
    );

    function automatic out_t o(input int col, input int lv, input int le, input int re, input int cc, input int st);
        out_t r;
        r.col = 2'(col);
        r.lv  = 1'(lv);
        r.le  = 1'(le);
        r.re  = 1'(re);
        r.cc  = 3'(cc);
        r.st  = 1'(st);
        return r;
    endfunction

    function automatic vec_t v(input logic sv, input logic [2:0] rgb, input logic clr, input out_t e);
        vec_t r;
        r.sv  = sv;
        r.rgb = rgb;
        r.clr = clr;
        r.exp = e;
        return r;
    endfunction

    function automatic out_t outs();
        return {locked_colour, lock_valid, lock_event, release_event, candidate_count, stale};
    endfunction

    task automatic cmp(input string name, input out_t a, input out_t x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got col=%0d lv=%0d le=%0d re=%0d cc=%0d st=%0d, expected col=%0d lv=%0d le=%0d re=%0d cc=%0d st=%0d",
                     name, a.col, a.lv, a.le, a.re, a.cc, a.st, x.col, x.lv, x.le, x.re, x.cc, x.st);
        end
    endtask

    task automatic cmp_val(input string name, input int a, input int x);
        checks++;
        if (a != x) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, a, x);
        end
    endtask

    // drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(input string name, input logic sv, input logic [2:0] rgb, input logic clr, input out_t e);
        @(negedge clk);
        sample_valid = sv;
        {red_detected, green_detected, blue_detected} = rgb;
        clear = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            cmp(name, outs(), sb.pop_front());
        end
    endtask

    initial begin
        int exp_locks, exp_conf;
        tbl.push_back(v(1'b1, R,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(0,0,0,0,2,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(0,0,0,0,3,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(1,1,1,0,4,0)));
        tbl.push_back(v(1'b0, N,   1'b0, o(1,1,0,0,4,0)));
        tbl.push_back(v(1'b1, N,   1'b0, o(1,1,0,0,4,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(1,1,0,0,4,0)));
        tbl.push_back(v(1'b1, N,   1'b0, o(1,1,0,0,4,0)));
        tbl.push_back(v(1'b1, N,   1'b0, o(1,1,0,0,4,0)));
        tbl.push_back(v(1'b1, N,   1'b0, o(0,0,0,1,0,0)));
        tbl.push_back(v(1'b0, N,   1'b0, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,2,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,3,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, N,   1'b0, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, R,   1'b0, o(0,0,0,0,2,0)));
        tbl.push_back(v(1'b1, RG,  1'b0, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,2,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,3,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(2,1,1,0,4,0)));
        tbl.push_back(v(1'b1, G,   1'b1, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b0, N,   1'b0, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, RGB, 1'b0, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b0, N,   1'b1, o(0,0,0,0,0,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(0,0,0,0,1,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(0,0,0,0,2,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(0,0,0,0,3,0)));
        tbl.push_back(v(1'b1, B,   1'b0, o(3,1,1,0,4,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(3,1,0,0,4,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(3,1,0,0,4,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,1,0,0)));
        tbl.push_back(v(1'b1, G,   1'b0, o(0,0,0,0,1,0)));

        repeat (2) @(posedge clk);
        #1;
        cmp("reset_outputs", outs(), o(0,0,0,0,0,0));
        cmp_val("reset_lock_count", int'(lock_count), 0);
        cmp_val("reset_conflict_count", int'(conflict_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].sv, tbl[i].rgb, tbl[i].clr, tbl[i].exp);

        // lock blue, then let the stream stall until the watchdog fires
        step("stale_seed", 1'b1, B, 1'b0, o(0,0,0,0,1,0));
        step("stale_c2",   1'b1, B, 1'b0, o(0,0,0,0,2,0));
        step("stale_c3",   1'b1, B, 1'b0, o(0,0,0,0,3,0));
        step("stale_lock", 1'b1, B, 1'b0, o(3,1,1,0,4,0));
        for (int i = 0; i < STALE - 1; i++) step("stale_wait", 1'b0, N, 1'b0, o(3,1,0,0,4,0));
        step("stale_fire",  1'b0, N, 1'b0, o(0,0,0,1,0,1));
        step("stale_after", 1'b0, N, 1'b0, o(0,0,0,0,0,1));
        step("stale_recover", 1'b1, B, 1'b0, o(0,0,0,0,1,0));

        // a sample on the timeout cycle wins and the lock survives
        step("race_c2",   1'b1, B, 1'b0, o(0,0,0,0,2,0));
        step("race_c3",   1'b1, B, 1'b0, o(0,0,0,0,3,0));
        step("race_lock", 1'b1, B, 1'b0, o(3,1,1,0,4,0));
        for (int i = 0; i < STALE - 1; i++) step("race_wait", 1'b0, N, 1'b0, o(3,1,0,0,4,0));
        step("race_sample", 1'b1, B, 1'b0, o(3,1,0,0,4,0));
        step("race_after",  1'b0, N, 1'b0, o(3,1,0,0,4,0));

        // a candidate times out silently, then clear drops stale
        step("cand_clear", 1'b0, N, 1'b1, o(0,0,0,0,0,0));
        step("cand_seed",  1'b1, R, 1'b0, o(0,0,0,0,1,0));
        for (int i = 0; i < STALE - 1; i++) step("cand_wait", 1'b0, N, 1'b0, o(0,0,0,0,1,0));
        step("cand_stale",   1'b0, N, 1'b0, o(0,0,0,0,0,1));
        step("stale_clear",  1'b0, N, 1'b1, o(0,0,0,0,0,0));
        step("final_c1",   1'b1, R, 1'b0, o(0,0,0,0,1,0));
        step("final_c2",   1'b1, R, 1'b0, o(0,0,0,0,2,0));
        step("final_c3",   1'b1, R, 1'b0, o(0,0,0,0,3,0));
        step("final_lock", 1'b1, R, 1'b0, o(1,1,1,0,4,0));

`ifdef COLOUR_LOCK_STATS_EN
        exp_locks = 6;
        exp_conf  = 2;
`else
        exp_locks = 0;
        exp_conf  = 0;
`endif
        cmp_val("lock_count", int'(lock_count), exp_locks);
        cmp_val("conflict_count", int'(conflict_count), exp_conf);

        // asynchronous reset takes effect without a clock edge
        @(negedge clk);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset", outs(), o(0,0,0,0,0,0));
        cmp_val("async_reset_lock_count", int'(lock_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
